// File: rtl/pcie_link_seq.sv
// Power-up / recovery sequencer for the single-lane PCIe hard IP: sequences PLL and
// GXB powerdown and core reset, watches lock, calibration and LTSSM, retries on failure.
module pcie_link_seq #(
  parameter int unsigned PWRDN_CYC    = 64,
  parameter int unsigned LOCK_STABLE  = 1000,
  parameter int unsigned CAL_TIMEOUT  = 5000000,
  parameter int unsigned LINK_TIMEOUT = 10000000,
  parameter int unsigned DOWN_CYC     = 1000,
  parameter int unsigned RETRY_MAX    = 8,
  parameter int unsigned LED_DIV      = 22
) (
  input  logic       gclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       reconfig_busy,
  input  logic [4:0] ltssm,
  input  logic       restart,
  output logic       pll_powerdown,
  output logic       gxb_powerdown,
  output logic       pcie_rstn,
  output logic       link_up,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic       led
);

  typedef enum logic [2:0] {
    PWRDN     = 3'd0,
    WAIT_LOCK = 3'd1,
    WAIT_CAL  = 3'd2,
    WAIT_LINK = 3'd3,
    UP        = 3'd4,
    FAULT     = 3'd5
  } state_e;

  localparam logic [4:0]  LTSSM_L0   = 5'h0F;
  // Terminal counts are one less than the cycle counts: the counter starts at 0 on entry.
  localparam logic [23:0] PWRDN_LAST = 24'(PWRDN_CYC - 1);
  localparam logic [23:0] LOCK_LAST  = 24'(LOCK_STABLE - 1);
  localparam logic [23:0] CAL_LAST   = 24'(CAL_TIMEOUT - 1);
  localparam logic [23:0] LINK_LAST  = 24'(LINK_TIMEOUT - 1);
  localparam logic [23:0] DOWN_LAST  = 24'(DOWN_CYC - 1);
  localparam logic [4:0]  RETRY_LIM  = 5'(RETRY_MAX);

  logic [1:0] lock_sync_q;
  logic [1:0] busy_sync_q;
  logic [1:0][4:0] ltssm_sync_q;
  logic       locked_s, busy_s;
  logic [4:0] ltssm_s;

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q  <= '0;
      busy_sync_q  <= '0;
      ltssm_sync_q <= '0;
    end else begin
      lock_sync_q  <= {lock_sync_q[0], pll_locked};
      busy_sync_q  <= {busy_sync_q[0], reconfig_busy};
      ltssm_sync_q <= {ltssm_sync_q[0], ltssm};
    end
  end

  assign locked_s = lock_sync_q[1];
  assign busy_s   = busy_sync_q[1];
  assign ltssm_s  = ltssm_sync_q[1];

  state_e             state_q, state_d;
  logic [23:0]        cnt_q, cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic [LED_DIV-1:0] div_q, div_d;
  logic               led_q, led_d;
  logic               pll_pd_q, pll_pd_d;
  logic               gxb_pd_q, gxb_pd_d;
  logic               rstn_q, rstn_d;
  logic               link_q, link_d;
  logic               fault_q, fault_d;
  logic               fail;
  logic               tick_slow, tick_fast;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 24'd1;
    retry_d = retry_q;
    fail    = 1'b0;
    case (state_q)
      PWRDN:
        if (cnt_q == PWRDN_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK:
        if (!locked_s) cnt_d = '0;
        else if (cnt_q == LOCK_LAST) state_d = WAIT_CAL;
      WAIT_CAL:
        if (!locked_s || cnt_q == CAL_LAST) fail = 1'b1;
        else if (!busy_s) state_d = WAIT_LINK;
      WAIT_LINK:
        if (!locked_s || cnt_q == LINK_LAST) fail = 1'b1;
        else if (ltssm_s == LTSSM_L0) begin
          state_d = UP;
          retry_d = '0;
        end
      UP:
        if (!locked_s) fail = 1'b1;
        else if (ltssm_s == LTSSM_L0) cnt_d = '0;
        else if (cnt_q == DOWN_LAST) fail = 1'b1;
      FAULT:
        cnt_d = cnt_q;
      default:
        state_d = PWRDN;
    endcase
    if (fail) begin
      retry_d = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
      state_d = (({1'b0, retry_q} + 5'd1) >= RETRY_LIM) ? FAULT : PWRDN;
    end
    if (restart) begin
      retry_d = '0;
      state_d = PWRDN;
    end
    if (state_d != state_q || restart) cnt_d = '0;
  end

  // Outputs are registered from the next state so they move on the transition edge.
  always_comb begin
    pll_pd_d  = (state_d == PWRDN) || (state_d == FAULT);
    gxb_pd_d  = (state_d == PWRDN) || (state_d == FAULT) || (state_d == WAIT_LOCK);
    rstn_d    = (state_d == WAIT_LINK) || (state_d == UP);
    link_d    = (state_d == UP);
    fault_d   = (state_d == FAULT);
    div_d     = div_q + 1'b1;
    tick_slow = &div_q;
    tick_fast = &div_q[LED_DIV-4:0];
    led_d     = led_q;
    if (state_d == UP) led_d = 1'b1;
    else if ((state_d == FAULT) ? tick_fast : tick_slow) led_d = ~led_q;
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PWRDN;
      cnt_q    <= '0;
      retry_q  <= '0;
      div_q    <= '0;
      led_q    <= 1'b1;
      pll_pd_q <= 1'b1;
      gxb_pd_q <= 1'b1;
      rstn_q   <= 1'b0;
      link_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      div_q    <= div_d;
      led_q    <= led_d;
      pll_pd_q <= pll_pd_d;
      gxb_pd_q <= gxb_pd_d;
      rstn_q   <= rstn_d;
      link_q   <= link_d;
      fault_q  <= fault_d;
    end
  end

  assign pll_powerdown = pll_pd_q;
  assign gxb_powerdown = gxb_pd_q;
  assign pcie_rstn     = rstn_q;
  assign link_up       = link_q;
  assign fault         = fault_q;
  assign state         = state_q;
  assign retry_cnt     = retry_q;
  assign led           = led_q;

endmodule

// File: tb/tb_pcie_link_seq.sv
// Directed bench for pcie_link_seq: short parameters, cycle-exact expectations
// counted from known edges.
module tb_pcie_link_seq;
  logic       gclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b1;
  logic       reconfig_busy = 1'b1;
  logic [4:0] ltssm = 5'h00;
  logic       restart = 1'b0;
  logic       pll_powerdown, gxb_powerdown, pcie_rstn, link_up, fault, led;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  int checks = 0;
  int failures = 0;

  pcie_link_seq #(
    .PWRDN_CYC(4), .LOCK_STABLE(8), .CAL_TIMEOUT(40), .LINK_TIMEOUT(100),
    .DOWN_CYC(10), .RETRY_MAX(3), .LED_DIV(4)
  ) dut (
    .gclk(gclk), .rst_n(rst_n), .pll_locked(pll_locked), .reconfig_busy(reconfig_busy),
    .ltssm(ltssm), .restart(restart), .pll_powerdown(pll_powerdown),
    .gxb_powerdown(gxb_powerdown), .pcie_rstn(pcie_rstn), .link_up(link_up),
    .fault(fault), .state(state), .retry_cnt(retry_cnt), .led(led)
  );

  always #10 gclk = ~gclk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge gclk);
      #1;
    end
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (pll_powerdown !== 1'b1 || gxb_powerdown !== 1'b1) begin failures++; $display("FAIL rst_pd got=%b%b exp=11", pll_powerdown, gxb_powerdown); end
    checks++; if (pcie_rstn !== 1'b0 || link_up !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", pcie_rstn, link_up, fault); end
    checks++; if (retry_cnt !== 4'd0 || led !== 1'b1) begin failures++; $display("FAIL rst_retry_led got=%0d,%b exp=0,1", retry_cnt, led); end
  endtask

  task automatic test_nominal;
    rst_n = 1'b1;
    tick(3);
    checks++; if (state !== 3'd0 || pll_powerdown !== 1'b1) begin failures++; $display("FAIL nom_pwrdn_hold got=%0d,%b exp=0,1", state, pll_powerdown); end
    tick(1);
    checks++; if (state !== 3'd1 || pll_powerdown !== 1'b0 || gxb_powerdown !== 1'b1) begin failures++; $display("FAIL nom_wait_lock got=%0d,%b%b exp=1,01", state, pll_powerdown, gxb_powerdown); end
    tick(7);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL nom_lock_hold got=%0d exp=1", state); end
    tick(1);
    checks++; if (state !== 3'd2 || gxb_powerdown !== 1'b0 || pcie_rstn !== 1'b0) begin failures++; $display("FAIL nom_wait_cal got=%0d,%b%b exp=2,00", state, gxb_powerdown, pcie_rstn); end
    tick(8);
    reconfig_busy = 1'b0;
    tick(2);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL nom_cal_sync got=%0d exp=2", state); end
    tick(1);
    checks++; if (state !== 3'd3 || pcie_rstn !== 1'b1) begin failures++; $display("FAIL nom_wait_link got=%0d,%b exp=3,1", state, pcie_rstn); end
    tick(50);
    ltssm = 5'h0F;
    tick(2);
    checks++; if (state !== 3'd3 || link_up !== 1'b0) begin failures++; $display("FAIL nom_link_sync got=%0d,%b exp=3,0", state, link_up); end
    tick(1);
    checks++; if (state !== 3'd4 || link_up !== 1'b1) begin failures++; $display("FAIL nom_up got=%0d,%b exp=4,1", state, link_up); end
    checks++; if (led !== 1'b1 || retry_cnt !== 4'd0) begin failures++; $display("FAIL nom_up_led_retry got=%b,%0d exp=1,0", led, retry_cnt); end
  endtask

  task automatic test_link_drop;
    ltssm = 5'h02;
    tick(9);
    ltssm = 5'h0F;
    tick(10);
    checks++; if (state !== 3'd4 || retry_cnt !== 4'd0) begin failures++; $display("FAIL drop9_stay got=%0d,%0d exp=4,0", state, retry_cnt); end
    ltssm = 5'h02;
    tick(11);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL drop10_pre got=%0d exp=4", state); end
    tick(1);
    checks++; if (state !== 3'd0 || retry_cnt !== 4'd1 || pcie_rstn !== 1'b0) begin failures++; $display("FAIL drop10_fail got=%0d,%0d,%b exp=0,1,0", state, retry_cnt, pcie_rstn); end
  endtask

  task automatic test_lock_glitch;
    tick(4);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL glitch_enter got=%0d exp=1", state); end
    tick(3);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(4);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL glitch_restart got=%0d exp=1", state); end
    tick(5);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL glitch_hold got=%0d exp=1", state); end
    tick(1);
    checks++; if (state !== 3'd2 || retry_cnt !== 4'd1) begin failures++; $display("FAIL glitch_cal got=%0d,%0d exp=2,1", state, retry_cnt); end
  endtask

  task automatic test_lock_loss_up;
    ltssm = 5'h0F;
    tick(1);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL ll_wait_link got=%0d exp=3", state); end
    tick(2);
    checks++; if (state !== 3'd4 || retry_cnt !== 4'd0) begin failures++; $display("FAIL ll_up_clear got=%0d,%0d exp=4,0", state, retry_cnt); end
    pll_locked = 1'b0;
    tick(2);
    checks++; if (state !== 3'd4 || pcie_rstn !== 1'b1) begin failures++; $display("FAIL ll_pre got=%0d,%b exp=4,1", state, pcie_rstn); end
    tick(1);
    checks++; if (state !== 3'd0 || pcie_rstn !== 1'b0 || pll_powerdown !== 1'b1 || gxb_powerdown !== 1'b1) begin failures++; $display("FAIL ll_drop got=%0d,%b%b%b exp=0,011", state, pcie_rstn, pll_powerdown, gxb_powerdown); end
    checks++; if (retry_cnt !== 4'd1) begin failures++; $display("FAIL ll_retry got=%0d exp=1", retry_cnt); end
  endtask

  task automatic test_link_timeout;
    logic l0;
    restart = 1'b1; pll_locked = 1'b1; ltssm = 5'h02;
    tick(1);
    restart = 1'b0;
    checks++; if (state !== 3'd0 || retry_cnt !== 4'd0) begin failures++; $display("FAIL lt_restart got=%0d,%0d exp=0,0", state, retry_cnt); end
    for (int a = 1; a <= 2; a++) begin
      tick(112);
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL lt_pre%0d got=%0d exp=3", a, state); end
      tick(1);
      checks++; if (state !== 3'd0 || retry_cnt !== 4'(a)) begin failures++; $display("FAIL lt_fail%0d got=%0d,%0d exp=0,%0d", a, state, retry_cnt, a); end
    end
    tick(112);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL lt_pre3 got=%0d exp=3", state); end
    tick(1);
    checks++; if (state !== 3'd5 || fault !== 1'b1 || link_up !== 1'b0) begin failures++; $display("FAIL lt_fault got=%0d,%b%b exp=5,10", state, fault, link_up); end
    checks++; if (pll_powerdown !== 1'b1 || gxb_powerdown !== 1'b1 || pcie_rstn !== 1'b0) begin failures++; $display("FAIL lt_fault_out got=%b%b%b exp=110", pll_powerdown, gxb_powerdown, pcie_rstn); end
    l0 = led;
    tick(2);
    checks++; if (led === l0) begin failures++; $display("FAIL lt_fault_blink got=%b exp=%b", led, ~l0); end
    tick(20);
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL lt_fault_hold got=%0d exp=5", state); end
    restart = 1'b1; reconfig_busy = 1'b1;
    tick(1);
    restart = 1'b0;
    checks++; if (state !== 3'd0 || retry_cnt !== 4'd0 || fault !== 1'b0) begin failures++; $display("FAIL lt_recover got=%0d,%0d,%b exp=0,0,0", state, retry_cnt, fault); end
  endtask

  task automatic test_restart_vs_cal_timeout;
    tick(51);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL ct_pre got=%0d exp=2", state); end
    tick(1);
    checks++; if (state !== 3'd0 || retry_cnt !== 4'd1) begin failures++; $display("FAIL ct_fail got=%0d,%0d exp=0,1", state, retry_cnt); end
    tick(51);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL ct_pre2 got=%0d exp=2", state); end
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    reconfig_busy = 1'b0;
    checks++; if (state !== 3'd0 || retry_cnt !== 4'd0) begin failures++; $display("FAIL ct_restart_wins got=%0d,%0d exp=0,0", state, retry_cnt); end
    tick(4);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL ct_fresh_pwrdn got=%0d exp=1", state); end
  endtask

  task automatic test_async_reset;
    tick(10);
    checks++; if (state !== 3'd3 || pcie_rstn !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d,%b exp=3,1", state, pcie_rstn); end
    #4 rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || pcie_rstn !== 1'b0) begin failures++; $display("FAIL ar_state got=%0d,%b exp=0,0", state, pcie_rstn); end
    checks++; if (pll_powerdown !== 1'b1 || gxb_powerdown !== 1'b1 || led !== 1'b1) begin failures++; $display("FAIL ar_outs got=%b%b%b exp=111", pll_powerdown, gxb_powerdown, led); end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL ar_restart_hold got=%0d exp=0", state); end
    tick(1);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL ar_restart_lock got=%0d exp=1", state); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_link_drop();
    test_lock_glitch();
    test_lock_loss_up();
    test_link_timeout();
    test_restart_vs_cal_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pcie_link_seq.md
# pcie_link_seq

Power-up and recovery sequencer for the single-lane PCIe hard IP and its transceiver. It drives the PLL/GXB powerdown inputs and the PCIe core reset. It waits for PLL lock, transceiver offset-cancellation (reconfig busy) and LTSSM L0, and restarts the whole sequence on loss of lock, link drop or timeout. It sits in the top level between the system PLL/reconfig controller and the PCIe core, and it drives the status LED.

## Interface
Parameters:
- PWRDN_CYC, 64: cycles both powerdowns are held after (re)start.
- LOCK_STABLE, 1000: consecutive locked cycles required before releasing the GXB.
- CAL_TIMEOUT, 5000000: max cycles waiting for reconfig_busy low.
- LINK_TIMEOUT, 10000000: max cycles from core reset release to L0.
- DOWN_CYC, 1000: consecutive non-L0 cycles in UP that count as link loss.
- RETRY_MAX, 8: consecutive failed attempts before FAULT (1..15).
- LED_DIV, 22: LED blink half-period is 2^LED_DIV cycles.

Ports:
- gclk  in  1  50 MHz system clock; all logic runs on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock, asynchronous; 2-FF synchronized.
- reconfig_busy  in  1  offset-cancellation busy, asynchronous; 2-FF synchronized.
- ltssm  in  5  LTSSM state from PCIe test_out[4:0], asynchronous; each bit 2-FF synchronized; L0 = 5'h0F.
- restart  in  1  synchronous pulse: clear retry count, restart sequence.
- pll_powerdown  out  1  to PCIe IP PLL powerdown.
- gxb_powerdown  out  1  to PCIe IP GXB powerdown.
- pcie_rstn  out  1  PCIe core reset, active low.
- link_up  out  1  high only in UP.
- fault  out  1  high only in FAULT.
- state  out  3  current state encoding.
- retry_cnt  out  4  failed attempts since last success or restart.
- led  out  1  status LED.

## Operation
- States: PWRDN=0, WAIT_LOCK=1, WAIT_CAL=2, WAIT_LINK=3, UP=4, FAULT=5. Codes 6 and 7 go to PWRDN on the next cycle.
- One 24-bit cycle counter, cleared on every state change. All parameters must be < 2^24.
- Output levels per state:
  - PWRDN: pll_powerdown=1, gxb_powerdown=1, pcie_rstn=0.
  - WAIT_LOCK: pll_powerdown=0, gxb_powerdown=1, pcie_rstn=0.
  - WAIT_CAL: pll_powerdown=0, gxb_powerdown=0, pcie_rstn=0.
  - WAIT_LINK and UP: pll_powerdown=0, gxb_powerdown=0, pcie_rstn=1.
  - FAULT: same as PWRDN.
- PWRDN: after PWRDN_CYC cycles → WAIT_LOCK.
- WAIT_LOCK: counter increments while locked_s=1 and clears when locked_s=0. When the counter reaches LOCK_STABLE → WAIT_CAL. There is no timeout in this state.
- WAIT_CAL: busy_s=0 → WAIT_LINK. Counter reaching CAL_TIMEOUT → fail.
- WAIT_LINK: ltssm_s==5'h0F → UP and retry_cnt cleared. Counter reaching LINK_TIMEOUT → fail.
- UP: counter increments while ltssm_s≠L0 and clears on L0. Reaching DOWN_CYC → fail.
- Lock loss: locked_s=0 in WAIT_CAL, WAIT_LINK or UP → fail immediately.
- Fail action: if retry_cnt+1 ≥ RETRY_MAX → FAULT; otherwise retry_cnt+1 and → PWRDN. retry_cnt saturates at 15.
- FAULT: outputs held until rst_n or restart.
- restart: in any state, retry_cnt=0 and → PWRDN next cycle. restart has priority over every other transition in that cycle.
- If a fail condition and a success condition occur in the same cycle, the fail condition wins. Lock loss is checked before ltssm.
- led:
  - steady 1 in UP;
  - in FAULT, toggles every 2^(LED_DIV-3) cycles;
  - otherwise toggles every 2^LED_DIV cycles.
  - The free-running divider counter is never cleared except by reset.

## Timing
- Reset values: state=PWRDN, pll_powerdown=1, gxb_powerdown=1, pcie_rstn=0, link_up=0, fault=0, retry_cnt=0, led=1. All synchronizer flops reset to 0.
- All outputs are registered and derive from the state register. An output changes on the same edge as the state transition.
- Input to decision latency is 2 cycles (synchronizer), plus 1 cycle to the state update.
- Fixed sequence lengths:
  - PWRDN lasts exactly PWRDN_CYC cycles.
  - With lock steady from entry, WAIT_LOCK lasts LOCK_STABLE cycles.
- Assertion of rst_n mid-sequence forces the reset values asynchronously. The sequence restarts from PWRDN on the first edge after release.

## Test plan
- Nominal bring-up (PWRDN_CYC=4, LOCK_STABLE=8): lock high, busy low after 20 cycles, ltssm=0x0F 50 cycles after pcie_rstn rises → states 0→1→2→3→4, link_up=1, led=1, retry_cnt=0. Check pll_powerdown falls exactly 4 cycles after reset release.
- Lock glitch in WAIT_LOCK: drop lock for 1 cycle at count 5 → counter restarts, WAIT_CAL entered 8 cycles after lock returns, no retry increment.
- Link timeout (LINK_TIMEOUT=100, ltssm stuck at 0x02, RETRY_MAX=3) → three attempts, retry_cnt 1,2, then FAULT with fault=1 and all powerdowns=1. restart → state 0, retry_cnt=0.
- Link drop in UP (DOWN_CYC=10): ltssm leaves L0 for 9 cycles → stays UP. Leaves for 10 cycles → PWRDN, retry_cnt=1.
- Lock loss in UP → PWRDN on the 3rd edge after the pll_locked fall, pcie_rstn=0 and powerdowns=1 on that edge.
- rst_n asserted during WAIT_LINK → outputs take their reset values immediately, without waiting for a clock edge. Simultaneous restart and CAL timeout → PWRDN with retry_cnt=0.
